apb_i2c_regif: RTL and testbench
================================

Name: apb_i2c_regif

Overview:
- APB3 slave register interface that fronts an I2C core.
- Converts APB transfers into:
  - TX FIFO write strobes,
  - RX FIFO read strobes,
  - two 14-bit control registers (CONFIG, TIMEOUT).
- Returns RX data and error status to the bus, and drives TX/RX interrupt lines.
- Sits between the system APB fabric and the I2C controller/FIFOs.

Parameters:
- TX_ADDR, 32'h0000_0000, write-only TX data port.
- RX_ADDR, 32'h0000_0004, read-only RX data port.
- CONFIG_ADDR, 32'h0000_0008, R/W config register.
- TIMEOUT_ADDR, 32'h0000_000C, R/W timeout register.

Ports:
- PCLK in 1: single clock, rising edge.
- PRESETn in 1: synchronous, active-high reset (sampled on PCLK rising edge; port name kept per codebase).
- PSELx in 1: slave select.
- PWRITE in 1: 1=write, 0=read.
- PENABLE in 1: access phase.
- PADDR in 32: byte address, full 32-bit decode.
- PWDATA in 32: write data.
- READ_DATA_ON_RX in 32: RX FIFO head data.
- ERROR in 1: I2C core error flag.
- TX_EMPTY in 1: TX FIFO empty.
- RX_EMPTY in 1: RX FIFO empty.
- PRDATA out 32: read data.
- INTERNAL_I2C_REGISTER_CONFIG out 14: config register.
- INTERNAL_I2C_REGISTER_TIMEOUT out 14: timeout register.
- WRITE_DATA_ON_TX out 32: data to TX FIFO.
- WR_ENA out 1: TX FIFO push strobe.
- RD_ENA out 1: RX FIFO pop strobe.
- PREADY out 1: transfer ready.
- PSLVERR out 1: transfer error.
- INT_RX out 1: RX data-available interrupt.
- INT_TX out 1: TX-empty interrupt.

Behaviour:
- Reset (PRESETn=1 at a rising edge) clears all registered state to 0:
  - CONFIG, TIMEOUT, WRITE_DATA_ON_TX,
  - WR_ENA, RD_ENA, INT_RX, INT_TX,
  - internal setup flag.
- Reset overrides any in-progress transfer; no strobe is issued in the reset cycle.
- Phase tracking: internal flag setup_q <= PSELx & ~PENABLE each cycle.
- Access cycle: PSELx & PENABLE. Commit cycle: access cycle with setup_q=1.
  - Exactly one commit per APB transfer, even if PENABLE is held several cycles.
- PREADY: combinational, = PSELx & PENABLE (zero wait states); 0 otherwise.
- Address hit: PADDR must exactly equal one of the four parameters; any other address is unmapped.
- PSLVERR: combinational, = PREADY & (ERROR | unmapped | (PWRITE & RX_ADDR) | (~PWRITE & TX_ADDR)).
- Write commit, PWRITE=1, no error:
  - TX_ADDR: WRITE_DATA_ON_TX <= PWDATA; WR_ENA=1 for exactly the next cycle.
  - CONFIG_ADDR: CONFIG <= PWDATA[13:0]; upper bits ignored.
  - TIMEOUT_ADDR: TIMEOUT <= PWDATA[13:0]; upper bits ignored.
- Read commit, PWRITE=0, RX_ADDR, no error:
  - RD_ENA=1 for exactly the next cycle.
  - RD_ENA pulses even if RX_EMPTY=1; the FIFO handles underflow.
- Erroring transfer (PSLVERR=1): no register update, no WR_ENA/RD_ENA pulse.
- WR_ENA and RD_ENA are registered, each high for one cycle per commit, never both high together.
- PRDATA: combinational during read access cycles (PSELx & PENABLE & ~PWRITE); 32'h0 at all other times.
  - RX_ADDR: READ_DATA_ON_RX.
  - CONFIG_ADDR: {18'b0, CONFIG}.
  - TIMEOUT_ADDR: {18'b0, TIMEOUT}.
  - Unmapped or TX_ADDR: 0.
- Interrupts, registered, one-cycle latency:
  - INT_TX <= TX_EMPTY.
  - INT_RX <= ~RX_EMPTY.
- Back-to-back transfers (SETUP immediately after ACCESS) are supported; each produces its own commit.
- PSELx dropping mid-transfer (before the access cycle) aborts the transfer with no side effects.

Test Plan:
- Reset then idle: PRESETn=1 for 2 cycles, then 0 → all outputs 0, PREADY=0, PRDATA=0. With TX_EMPTY=1 and RX_EMPTY=1, the next cycle gives INT_TX=1, INT_RX=0.
- CONFIG write/readback:
  - Write PADDR=8, PWDATA=32'hFFFF_3A5C → CONFIG=14'h3A5C, PSLVERR=0.
  - Read PADDR=8 → PRDATA=32'h0000_3A5C with PREADY=1.
  - Repeat for TIMEOUT at PADDR=C.
- TX push:
  - Write PADDR=0, PWDATA=32'hDEAD_BEEF → WRITE_DATA_ON_TX=32'hDEAD_BEEF and a single WR_ENA pulse.
  - Hold PENABLE 3 cycles → still exactly one pulse.
- RX pop: READ_DATA_ON_RX=32'h1234_5678, read PADDR=4 → PRDATA=32'h1234_5678 in the access cycle and a single RD_ENA pulse next cycle.
- Errors, each giving PSLVERR=1 with PREADY=1 and no strobe or register change:
  - Write to PADDR=32'h10.
  - Write to PADDR=4.
  - Read with ERROR=1.
- Reset mid-transfer: assert PRESETn during the access cycle of a TX write → WR_ENA stays 0 and WRITE_DATA_ON_TX=0.

Source files
------------

// File: rtl/apb_i2c_regif.sv
// -----------------------------------------------------------------------------
// apb_i2c_regif
// APB3 slave register interface in front of an I2C core. APB transfers become
// TX FIFO push strobes, RX FIFO pop strobes and updates of two 14-bit control
// registers (CONFIG, TIMEOUT). RX data and error status are returned on the
// bus, and the TX/RX interrupt lines are registered copies of the FIFO flags.
//
// Ports:
//   PCLK, PRESETn                 clock, synchronous active-high reset
//   PSELx, PENABLE, PWRITE        APB control
//   PADDR[31:0], PWDATA[31:0]     APB address / write data
//   PRDATA[31:0], PREADY, PSLVERR APB response (combinational, zero wait)
//   READ_DATA_ON_RX[31:0]         RX FIFO head data
//   ERROR, TX_EMPTY, RX_EMPTY     I2C core / FIFO status
//   INTERNAL_I2C_REGISTER_CONFIG  CONFIG register (14 bits)
//   INTERNAL_I2C_REGISTER_TIMEOUT TIMEOUT register (14 bits)
//   WRITE_DATA_ON_TX[31:0]        data presented to the TX FIFO
//   WR_ENA, RD_ENA                one-cycle TX push / RX pop strobes
//   INT_RX, INT_TX                RX data-available / TX-empty interrupts
// -----------------------------------------------------------------------------
module apb_i2c_regif #(
    parameter logic [31:0] TX_ADDR      = 32'h0000_0000,
    parameter logic [31:0] RX_ADDR      = 32'h0000_0004,
    parameter logic [31:0] CONFIG_ADDR  = 32'h0000_0008,
    parameter logic [31:0] TIMEOUT_ADDR = 32'h0000_000C
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        PSELx,
    input  logic        PWRITE,
    input  logic        PENABLE,
    input  logic [31:0] PADDR,
    input  logic [31:0] PWDATA,
    input  logic [31:0] READ_DATA_ON_RX,
    input  logic        ERROR,
    input  logic        TX_EMPTY,
    input  logic        RX_EMPTY,
    output logic [31:0] PRDATA,
    output logic [13:0] INTERNAL_I2C_REGISTER_CONFIG,
    output logic [13:0] INTERNAL_I2C_REGISTER_TIMEOUT,
    output logic [31:0] WRITE_DATA_ON_TX,
    output logic        WR_ENA,
    output logic        RD_ENA,
    output logic        PREADY,
    output logic        PSLVERR,
    output logic        INT_RX,
    output logic        INT_TX
);

    logic        setup_q,   setup_d;
    logic [13:0] config_q,  config_d;
    logic [13:0] timeout_q, timeout_d;
    logic [31:0] tx_data_q, tx_data_d;
    logic        wr_ena_q,  wr_ena_d;
    logic        rd_ena_q,  rd_ena_d;
    logic        int_rx_q,  int_rx_d;
    logic        int_tx_q,  int_tx_d;

    logic        hit_tx_s, hit_rx_s, hit_cfg_s, hit_tmo_s, unmapped_s;
    logic        access_s, commit_s, pslverr_s;
    logic [31:0] prdata_s;

    // Address decode and APB response; a commit is the first access cycle
    // after a setup cycle, so a held PENABLE does not repeat side effects.
    always_comb begin
        hit_tx_s   = (PADDR == TX_ADDR);
        hit_rx_s   = (PADDR == RX_ADDR);
        hit_cfg_s  = (PADDR == CONFIG_ADDR);
        hit_tmo_s  = (PADDR == TIMEOUT_ADDR);
        unmapped_s = ~(hit_tx_s | hit_rx_s | hit_cfg_s | hit_tmo_s);
        access_s   = PSELx & PENABLE;
        commit_s   = access_s & setup_q;
        // Writing the RX port or reading the TX port is a direction error.
        pslverr_s  = access_s & (ERROR | unmapped_s |
                                 (PWRITE & hit_rx_s) | (~PWRITE & hit_tx_s));
    end

    // Read data mux, driven only during read access cycles.
    always_comb begin
        prdata_s = 32'h0000_0000;
        if (access_s && !PWRITE) begin
            if (hit_rx_s) begin
                prdata_s = READ_DATA_ON_RX;
            end else if (hit_cfg_s) begin
                prdata_s = {18'b0, config_q};
            end else if (hit_tmo_s) begin
                prdata_s = {18'b0, timeout_q};
            end else begin
                prdata_s = 32'h0000_0000;
            end
        end else begin
            prdata_s = 32'h0000_0000;
        end
    end

    // Next-state logic: register updates and strobes on error-free commits.
    always_comb begin
        setup_d   = PSELx & ~PENABLE;
        config_d  = config_q;
        timeout_d = timeout_q;
        tx_data_d = tx_data_q;
        wr_ena_d  = 1'b0;
        rd_ena_d  = 1'b0;
        int_tx_d  = TX_EMPTY;
        int_rx_d  = ~RX_EMPTY;
        if (commit_s && !pslverr_s) begin
            if (PWRITE) begin
                if (hit_tx_s) begin
                    tx_data_d = PWDATA;
                    wr_ena_d  = 1'b1;
                end else if (hit_cfg_s) begin
                    config_d  = PWDATA[13:0];
                end else if (hit_tmo_s) begin
                    timeout_d = PWDATA[13:0];
                end else begin
                    wr_ena_d  = 1'b0;
                end
            end else begin
                // Pops even when the FIFO is empty; underflow is the FIFO's job.
                if (hit_rx_s) begin
                    rd_ena_d = 1'b1;
                end else begin
                    rd_ena_d = 1'b0;
                end
            end
        end else begin
            wr_ena_d = 1'b0;
            rd_ena_d = 1'b0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            setup_q   <= 1'b0;
            config_q  <= 14'h0000;
            timeout_q <= 14'h0000;
            tx_data_q <= 32'h0000_0000;
            wr_ena_q  <= 1'b0;
            rd_ena_q  <= 1'b0;
            int_rx_q  <= 1'b0;
            int_tx_q  <= 1'b0;
        end else begin
            setup_q   <= setup_d;
            config_q  <= config_d;
            timeout_q <= timeout_d;
            tx_data_q <= tx_data_d;
            wr_ena_q  <= wr_ena_d;
            rd_ena_q  <= rd_ena_d;
            int_rx_q  <= int_rx_d;
            int_tx_q  <= int_tx_d;
        end
    end

    assign PREADY                        = access_s;
    assign PSLVERR                       = pslverr_s;
    assign PRDATA                        = prdata_s;
    assign INTERNAL_I2C_REGISTER_CONFIG  = config_q;
    assign INTERNAL_I2C_REGISTER_TIMEOUT = timeout_q;
    assign WRITE_DATA_ON_TX              = tx_data_q;
    assign WR_ENA                        = wr_ena_q;
    assign RD_ENA                        = rd_ena_q;
    assign INT_RX                        = int_rx_q;
    assign INT_TX                        = int_tx_q;

endmodule

// File: tb/tb_apb_i2c_regif.sv
// -----------------------------------------------------------------------------
// tb_apb_i2c_regif
// Self-checking bench for apb_i2c_regif: directed scenarios plus randomized
// transfers checked against a transfer-level register model.
// -----------------------------------------------------------------------------
module tb_apb_i2c_regif;

    logic        clk = 1'b0;
    logic        PRESETn = 1'b1;
    logic        PSELx = 1'b0, PWRITE = 1'b0, PENABLE = 1'b0;
    logic [31:0] PADDR = 32'h0, PWDATA = 32'h0, READ_DATA_ON_RX = 32'h0;
    logic        ERROR = 1'b0, TX_EMPTY = 1'b1, RX_EMPTY = 1'b1;
    logic [31:0] PRDATA;
    logic [13:0] CFG, TMO;
    logic [31:0] WRITE_DATA_ON_TX;
    logic        WR_ENA, RD_ENA, PREADY, PSLVERR, INT_RX, INT_TX;

    always #5 clk = ~clk;

    apb_i2c_regif dut (
        .PCLK(clk), .PRESETn(PRESETn), .PSELx(PSELx), .PWRITE(PWRITE),
        .PENABLE(PENABLE), .PADDR(PADDR), .PWDATA(PWDATA),
        .READ_DATA_ON_RX(READ_DATA_ON_RX), .ERROR(ERROR),
        .TX_EMPTY(TX_EMPTY), .RX_EMPTY(RX_EMPTY), .PRDATA(PRDATA),
        .INTERNAL_I2C_REGISTER_CONFIG(CFG),
        .INTERNAL_I2C_REGISTER_TIMEOUT(TMO),
        .WRITE_DATA_ON_TX(WRITE_DATA_ON_TX), .WR_ENA(WR_ENA), .RD_ENA(RD_ENA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .INT_RX(INT_RX), .INT_TX(INT_TX)
    );

    int n_vec = 0;
    int n_err = 0;

    // Strobe monitor: counts cycles each strobe is seen high.
    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0;
    always @(negedge clk) begin
        if (WR_ENA === 1'b1) wr_cnt <= wr_cnt + 1;
        if (RD_ENA === 1'b1) rd_cnt <= rd_cnt + 1;
        if (WR_ENA === 1'b1 && RD_ENA === 1'b1) both_cnt <= both_cnt + 1;
    end

    // Reference model state
    logic [13:0] m_cfg = 14'h0, m_tmo = 14'h0;
    logic [31:0] m_txd = 32'h0;

    function automatic logic is_mapped(input logic [31:0] a);
        return (a == 32'h0) || (a == 32'h4) || (a == 32'h8) || (a == 32'hC);
    endfunction

    function automatic logic exp_err(input logic wr, input logic [31:0] a, input logic e);
        return e || !is_mapped(a) || (wr && a == 32'h4) || (!wr && a == 32'h0);
    endfunction

    function automatic logic [31:0] exp_rdata(input logic wr, input logic [31:0] a);
        if (wr) return 32'h0;
        if (a == 32'h4) return READ_DATA_ON_RX;
        if (a == 32'h8) return {18'h0, m_cfg};
        if (a == 32'hC) return {18'h0, m_tmo};
        return 32'h0;
    endfunction

    // Update model for a completed transfer; returns expected push/pop counts.
    task automatic model_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                              input logic e, output int ewr, output int erd);
        ewr = 0; erd = 0;
        if (!exp_err(wr, a, e)) begin
            if (wr && a == 32'h0) begin m_txd = d; ewr = 1; end
            if (wr && a == 32'h8) m_cfg = d[13:0];
            if (wr && a == 32'hC) m_tmo = d[13:0];
            if (!wr && a == 32'h4) erd = 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    // One APB transfer with PENABLE held for 'hold' access cycles; captures
    // the response seen in the first access cycle.
    task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                            input int hold, output logic o_rdy, output logic o_err,
                            output logic [31:0] o_rd);
        @(negedge clk);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a; PWDATA = d;
        @(negedge clk);
        PENABLE = 1'b1;
        #1;
        o_rdy = PREADY; o_err = PSLVERR; o_rd = PRDATA;
        for (int i = 1; i < hold; i++) @(negedge clk);
        @(negedge clk);
        PSELx = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic test_reset;
        PRESETn = 1'b1; TX_EMPTY = 1'b1; RX_EMPTY = 1'b1;
        repeat (2) @(negedge clk);
        PRESETn = 1'b0;
        #1;
        n_vec++;
        if ({CFG, TMO, WRITE_DATA_ON_TX, WR_ENA, RD_ENA, INT_TX, INT_RX,
             PREADY, PSLVERR, PRDATA} !== 100'h0) begin
            n_err++;
            $display("FAIL reset_outputs: cfg=%h tmo=%h txd=%h wr=%b rd=%b itx=%b irx=%b rdy=%b err=%b prdata=%h, all required 0",
                     CFG, TMO, WRITE_DATA_ON_TX, WR_ENA, RD_ENA, INT_TX, INT_RX, PREADY, PSLVERR, PRDATA);
        end
        @(negedge clk); #1;
        n_vec++;
        if ({INT_TX, INT_RX} !== 2'b10) begin
            n_err++;
            $display("FAIL reset_interrupts: got tx=%b rx=%b, required tx=1 rx=0", INT_TX, INT_RX);
        end
    endtask

    task automatic test_abort;
        int w0, r0;
        idle(2);
        w0 = wr_cnt; r0 = rd_cnt;
        @(negedge clk);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h8; ERROR = 1'b1;
        #1;
        n_vec++;
        if ({PREADY, PSLVERR, PRDATA} !== 34'h0) begin
            n_err++;
            $display("FAIL setup_phase: rdy=%b err=%b prdata=%h, required 0", PREADY, PSLVERR, PRDATA);
        end
        @(negedge clk);
        PSELx = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; ERROR = 1'b0;
        idle(3);
        n_vec++;
        if (wr_cnt != w0 || rd_cnt != r0 || WRITE_DATA_ON_TX !== m_txd) begin
            n_err++;
            $display("FAIL abort: wr=%0d rd=%0d txd=%h, required 0 0 %h", wr_cnt - w0, rd_cnt - r0, WRITE_DATA_ON_TX, m_txd);
        end
    endtask

    task automatic test_cfg_tmo;
        logic rdy, err; logic [31:0] rd, d;
        int ewr, erd;
        apb_xfer(1'b1, 32'h8, 32'hFFFF_3A5C, 1, rdy, err, rd);
        model_xfer(1'b1, 32'h8, 32'hFFFF_3A5C, 1'b0, ewr, erd);
        idle(1);
        n_vec++;
        if (err !== 1'b0 || rdy !== 1'b1 || CFG !== 14'h3A5C) begin
            n_err++;
            $display("FAIL cfg_write: err=%b rdy=%b cfg=%h, required 0 1 3a5c", err, rdy, CFG);
        end
        apb_xfer(1'b0, 32'h8, 32'h0, 1, rdy, err, rd);
        n_vec++;
        if (rd !== 32'h0000_3A5C || rdy !== 1'b1 || err !== 1'b0) begin
            n_err++;
            $display("FAIL cfg_read: prdata=%h rdy=%b err=%b, required 00003a5c 1 0", rd, rdy, err);
        end
        d = $urandom;
        apb_xfer(1'b1, 32'hC, d, 1, rdy, err, rd);
        model_xfer(1'b1, 32'hC, d, 1'b0, ewr, erd);
        apb_xfer(1'b0, 32'hC, 32'h0, 2, rdy, err, rd);
        n_vec++;
        if (rd !== {18'h0, d[13:0]} || TMO !== d[13:0] || err !== 1'b0) begin
            n_err++;
            $display("FAIL tmo_rw: prdata=%h tmo=%h err=%b, required %h", rd, TMO, err, {18'h0, d[13:0]});
        end
    endtask

    task automatic test_tx_push;
        logic rdy, err; logic [31:0] rd, d;
        int w0, ewr, erd;
        for (int h = 1; h <= 3; h += 2) begin
            d = (h == 1) ? 32'hDEAD_BEEF : $urandom;
            w0 = wr_cnt;
            apb_xfer(1'b1, 32'h0, d, h, rdy, err, rd);
            model_xfer(1'b1, 32'h0, d, 1'b0, ewr, erd);
            idle(2);
            n_vec++;
            if (WRITE_DATA_ON_TX !== d || wr_cnt - w0 != 1 || err !== 1'b0) begin
                n_err++;
                $display("FAIL tx_push_hold%0d: txd=%h pulses=%0d err=%b, required %h 1 0", h, WRITE_DATA_ON_TX, wr_cnt - w0, err, d);
            end
        end
    endtask

    task automatic test_rx_pop;
        logic rdy, err; logic [31:0] rd;
        int r0, w0;
        READ_DATA_ON_RX = 32'h1234_5678;
        r0 = rd_cnt; w0 = wr_cnt;
        apb_xfer(1'b0, 32'h4, 32'h0, 1, rdy, err, rd);
        idle(2);
        n_vec++;
        if (rd !== 32'h1234_5678 || rdy !== 1'b1 || rd_cnt - r0 != 1 || wr_cnt != w0) begin
            n_err++;
            $display("FAIL rx_pop: prdata=%h rdy=%b rd_pulses=%0d wr_pulses=%0d, required 12345678 1 1 0", rd, rdy, rd_cnt - r0, wr_cnt - w0);
        end
    endtask

    task automatic test_errors;
        logic rdy, err; logic [31:0] rd;
        int w0, r0;
        logic        wr_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [31:0] a_t  [4] = '{32'h10, 32'h4, 32'h4, 32'h8};
        logic        e_t  [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            w0 = wr_cnt; r0 = rd_cnt;
            ERROR = e_t[i];
            apb_xfer(wr_t[i], a_t[i], $urandom, 1, rdy, err, rd);
            ERROR = 1'b0;
            idle(2);
            n_vec++;
            if (err !== 1'b1 || rdy !== 1'b1 || wr_cnt != w0 || rd_cnt != r0 ||
                CFG !== m_cfg || TMO !== m_tmo || WRITE_DATA_ON_TX !== m_txd) begin
                n_err++;
                $display("FAIL error_case%0d: err=%b rdy=%b wr=%0d rd=%0d cfg=%h, required 1 1 0 0 %h",
                         i, err, rdy, wr_cnt - w0, rd_cnt - r0, CFG, m_cfg);
            end
        end
    endtask

    task automatic test_reset_mid;
        int w0;
        idle(2);
        w0 = wr_cnt;
        @(negedge clk);
        PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h0; PWDATA = 32'hCAFE_F00D;
        @(negedge clk);
        PENABLE = 1'b1; PRESETn = 1'b1;
        @(negedge clk);
        PRESETn = 1'b0;
        #1;
        m_cfg = 14'h0; m_tmo = 14'h0; m_txd = 32'h0;
        n_vec++;
        if (WR_ENA !== 1'b0 || WRITE_DATA_ON_TX !== 32'h0 || CFG !== 14'h0) begin
            n_err++;
            $display("FAIL reset_mid: wr_ena=%b txd=%h cfg=%h, required 0 0 0", WR_ENA, WRITE_DATA_ON_TX, CFG);
        end
        @(negedge clk);
        PSELx = 1'b0; PENABLE = 1'b0;
        idle(2);
        n_vec++;
        if (wr_cnt != w0 || WRITE_DATA_ON_TX !== 32'h0) begin
            n_err++;
            $display("FAIL reset_mid_after: pulses=%0d txd=%h, required 0 0", wr_cnt - w0, WRITE_DATA_ON_TX);
        end
    endtask

    task automatic test_back_to_back;
        int w0, r0;
        logic [31:0] d [3];
        logic [31:0] a [3] = '{32'h8, 32'hC, 32'h0};
        w0 = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            d[i] = $urandom;
            @(negedge clk);
            PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = a[i]; PWDATA = d[i];
            @(negedge clk);
            PENABLE = 1'b1;
        end
        @(negedge clk);
        PSELx = 1'b0; PENABLE = 1'b0;
        m_cfg = d[0][13:0]; m_tmo = d[1][13:0]; m_txd = d[2];
        idle(2);
        n_vec++;
        if (CFG !== m_cfg || TMO !== m_tmo || WRITE_DATA_ON_TX !== m_txd || wr_cnt - w0 != 1) begin
            n_err++;
            $display("FAIL b2b_write: cfg=%h tmo=%h txd=%h pulses=%0d, required %h %h %h 1",
                     CFG, TMO, WRITE_DATA_ON_TX, wr_cnt - w0, m_cfg, m_tmo, m_txd);
        end
        r0 = rd_cnt;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            PSELx = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = 32'h4;
            @(negedge clk);
            PENABLE = 1'b1;
        end
        @(negedge clk);
        PSELx = 1'b0; PENABLE = 1'b0;
        idle(2);
        n_vec++;
        if (rd_cnt - r0 != 2) begin
            n_err++;
            $display("FAIL b2b_read: pops=%0d, required 2", rd_cnt - r0);
        end
    endtask

    task automatic test_random;
        logic rdy, err, wr, e; logic [31:0] rd, a, d;
        int w0, r0, ewr, erd, h;
        for (int n = 0; n < 40; n++) begin
            case ($urandom_range(0, 5))
                0: a = 32'h0;
                1: a = 32'h4;
                2: a = 32'h8;
                3: a = 32'hC;
                4: a = 32'h10 + {$urandom_range(0, 15), 2'b00};
                default: a = $urandom;
            endcase
            wr = $urandom_range(0, 1);
            d = $urandom;
            e = ($urandom_range(0, 7) == 0);
            h = $urandom_range(1, 3);
            READ_DATA_ON_RX = $urandom;
            ERROR = e;
            w0 = wr_cnt; r0 = rd_cnt;
            apb_xfer(wr, a, d, h, rdy, err, rd);
            ERROR = 1'b0;
            n_vec++;
            if (rdy !== 1'b1 || err !== exp_err(wr, a, e) || rd !== exp_rdata(wr, a)) begin
                n_err++;
                $display("FAIL rand%0d_resp: wr=%b a=%h rdy=%b err=%b prdata=%h, required 1 %b %h",
                         n, wr, a, rdy, err, rd, exp_err(wr, a, e), exp_rdata(wr, a));
            end
            model_xfer(wr, a, d, e, ewr, erd);
            idle(2);
            n_vec++;
            if (wr_cnt - w0 != ewr || rd_cnt - r0 != erd || CFG !== m_cfg ||
                TMO !== m_tmo || WRITE_DATA_ON_TX !== m_txd) begin
                n_err++;
                $display("FAIL rand%0d_state: wr=%0d rd=%0d cfg=%h tmo=%h txd=%h, required %0d %0d %h %h %h",
                         n, wr_cnt - w0, rd_cnt - r0, CFG, TMO, WRITE_DATA_ON_TX, ewr, erd, m_cfg, m_tmo, m_txd);
            end
        end
    endtask

    task automatic test_interrupts;
        logic te, re;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            te = $urandom_range(0, 1); re = $urandom_range(0, 1);
            TX_EMPTY = te; RX_EMPTY = re;
            @(negedge clk); #1;
            n_vec++;
            if (INT_TX !== te || INT_RX !== ~re) begin
                n_err++;
                $display("FAIL irq%0d: tx=%b rx=%b, required %b %b", i, INT_TX, INT_RX, te, ~re);
            end
        end
    endtask

    initial begin
        test_reset();
        test_abort();
        test_cfg_tmo();
        test_tx_push();
        test_rx_pop();
        test_errors();
        test_back_to_back();
        test_random();
        test_interrupts();
        test_reset_mid();
        idle(2);
        n_vec++;
        if (both_cnt != 0) begin
            n_err++;
            $display("FAIL strobe_overlap: both high %0d cycles, required 0", both_cnt);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
